// File: rtl/cache_refill_ctrl.sv
// Miss-handling engine: optional dirty-victim write-back burst, then a line refill burst,
// then a one-cycle refresh pulse that commits the new tag and line.
module cache_refill_ctrl #(
  parameter int unsigned LINE_WORDS = 16,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_miss,
  input  logic                    i_write_back,
  input  logic [31:0]             i_axi_raddr,
  input  logic [31:0]             i_axi_waddr,
  input  logic [32*LINE_WORDS-1:0] i_victim_line,
  output logic                    o_refresh,
  output logic [32*LINE_WORDS-1:0] o_refill_line,
  output logic                    o_busy,
  output logic [3:0]              o_arid,
  output logic [31:0]             o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [31:0]             i_rdata,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  output logic [3:0]              o_awid,
  output logic [31:0]             o_awaddr,
  output logic [7:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [31:0]             o_wdata,
  output logic [3:0]              o_wstrb,
  output logic                    o_wlast,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic                    i_bvalid,
  output logic                    o_bready
);

  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_AW, S_WB_W, S_WB_B, S_RD_AR, S_RD_R, S_DONE
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [31:0]             r_raddr;
  logic [31:0]             r_waddr;
  logic [32*LINE_WORDS-1:0] r_victim;
  logic [32*LINE_WORDS-1:0] r_refill_line;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic                    w_unused_rlast;

  // The burst length is fixed, so the beat counter alone marks the end of a read burst.
  assign w_unused_rlast = i_rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_raddr       <= '0;
      r_waddr       <= '0;
      r_victim      <= '0;
      r_refill_line <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_miss) begin
            r_raddr  <= i_axi_raddr;
            r_waddr  <= i_axi_waddr;
            r_victim <= i_victim_line;
            if (i_write_back) begin
              r_state   <= S_WB_AW;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= S_RD_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_WB_AW: begin
          if (i_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= S_WB_W;
          end
        end
        S_WB_W: begin
          if (i_wready) begin
            if (r_cnt == LAST_BEAT) begin
              r_cnt    <= '0;
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_WB_B;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WB_B: begin
          if (i_bvalid) begin
            r_bready  <= 1'b0;
            r_arvalid <= 1'b1;
            r_state   <= S_RD_AR;
          end
        end
        S_RD_AR: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (i_rvalid) begin
            r_refill_line[32*r_cnt +: 32] <= i_rdata;
            if (r_cnt == LAST_BEAT) begin
              r_cnt    <= '0;
              r_rready <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush that drops miss before DONE suppresses the commit.
  assign o_refresh     = (r_state == S_DONE) & i_miss;
  assign o_refill_line = r_refill_line;
  assign o_busy        = (r_state != S_IDLE);

  assign o_arid    = AXI_ID;
  assign o_araddr  = r_raddr;
  assign o_arlen   = 8'(LINE_WORDS - 1);
  assign o_arsize  = 3'b010;
  assign o_arburst = 2'b01;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

  assign o_awid    = AXI_ID;
  assign o_awaddr  = r_waddr;
  assign o_awlen   = 8'(LINE_WORDS - 1);
  assign o_awsize  = 3'b010;
  assign o_awburst = 2'b01;
  assign o_awvalid = r_awvalid;

  assign o_wdata   = r_victim[32*r_cnt +: 32];
  assign o_wstrb   = 4'hF;
  assign o_wlast   = r_wvalid & (r_cnt == LAST_BEAT);
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: a randomized AXI slave and a transaction-level model of the
// expected bursts, refresh pulse and refill line.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_miss, i_write_back;
  logic [31:0]  i_axi_raddr, i_axi_waddr;
  logic [511:0] i_victim_line;
  logic         o_refresh, o_busy;
  logic [511:0] o_refill_line;
  logic [3:0]   o_arid, o_awid;
  logic [31:0]  o_araddr, o_awaddr, o_wdata;
  logic [7:0]   o_arlen, o_awlen;
  logic [2:0]   o_arsize, o_awsize;
  logic [1:0]   o_arburst, o_awburst;
  logic         o_arvalid, i_arready, o_rready, o_awvalid, i_awready;
  logic [31:0]  i_rdata;
  logic         i_rlast, i_rvalid;
  logic [3:0]   o_wstrb;
  logic         o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;

  int n_checks = 0;
  int n_errors = 0;

  logic [511:0] vic_line;
  logic [511:0] rd_line;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.LINE_WORDS(16), .AXI_ID(4'h0)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_write_back(i_write_back),
    .i_axi_raddr(i_axi_raddr), .i_axi_waddr(i_axi_waddr), .i_victim_line(i_victim_line),
    .o_refresh(o_refresh), .o_refill_line(o_refill_line), .o_busy(o_busy),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_miss = 0; i_write_back = 0; i_arready = 0; i_rvalid = 0; i_rlast = 0;
    i_rdata = '0; i_awready = 0; i_wready = 0; i_bvalid = 0;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_arvalid"}, o_arvalid, 0);
    check_val({tag, "_awvalid"}, o_awvalid, 0);
    check_val({tag, "_wvalid"},  o_wvalid,  0);
    check_val({tag, "_rready"},  o_rready,  0);
    check_val({tag, "_bready"},  o_bready,  0);
    check_val({tag, "_wlast"},   o_wlast,   0);
    check_val({tag, "_refresh"}, o_refresh, 0);
    check_val({tag, "_busy"},    o_busy,    0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      vic_line[32*i +: 32] = $urandom;
      rd_line[32*i +: 32]  = $urandom;
    end
  endtask

  // One miss as seen from the bus. Cycle index k is the cycle N+k, where edge N samples the miss.
  // drop_at: beat count at which miss is withdrawn (-1 none); rst_at: W beat count at which rst
  // is pulsed (-1 none); early_rlast: R beat index given a premature rlast (-1 none);
  // exp_ar/exp_ref: expected cycle of first arvalid and of refresh (-1 to skip).
  task automatic run_miss(input string tag, input logic [31:0] raddr, input logic [31:0] waddr,
                          input bit wb, input bit stall, input int drop_at, input int rst_at,
                          input int early_rlast, input int exp_ar, input int exp_ref);
    int  aw_n = 0, wbeat = 0, b_n = 0, ar_n = 0, rbeat = 0, ref_n = 0;
    int  w_done = -100, ar_idx = -100, first_ar = -1, ref_idx = -1, rst_cyc = -1;
    bit  done = 0, saw_ref = 0, dropped = 0, r_hs = 0, reset_case = 0;
    bit  p_aw = 0, p_w = 0, p_ar = 0;
    logic [31:0] p_awaddr = '0, p_araddr = '0, p_wdata = '0;
    logic        p_wlast = 0;

    @(posedge clk); #1;
    i_miss = 1; i_write_back = wb; i_axi_raddr = raddr; i_axi_waddr = waddr;
    i_victim_line = vic_line;
    i_awready = 1; i_wready = 1; i_arready = 1; i_rvalid = 0; i_bvalid = 0;

    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (saw_ref) i_miss = 0;
        if (drop_at >= 0 && rbeat >= drop_at) begin i_miss = 0; dropped = 1; end
        if (rst_cyc >= 0) rst = 0;
        if (rst_at >= 0 && rst_cyc < 0 && wbeat == rst_at) begin
          rst = 1; i_miss = 0; rst_cyc = cyc;
        end
        i_awready = stall ? 1'($urandom % 2) : 1'b1;
        i_wready  = stall ? 1'($urandom % 2) : 1'b1;
        i_arready = stall ? 1'($urandom % 2) : 1'b1;
        if (wbeat == 16 && b_n == 0 && cyc >= w_done + 2)
          i_bvalid = i_bvalid ? 1'b1 : (!stall || 1'($urandom % 2));
        else
          i_bvalid = 0;
        if (ar_n == 1 && rbeat < 16 && cyc >= ar_idx + 1)
          i_rvalid = (i_rvalid && !r_hs) ? 1'b1 : (!stall || 1'($urandom % 2));
        else
          i_rvalid = 0;
        i_rdata = (rbeat < 16) ? rd_line[32*rbeat +: 32] : 32'hDEAD_BEEF;
        i_rlast = (rbeat == 15) || (rbeat == early_rlast);
      end

      @(negedge clk);
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        check_quiet({tag, "_after_rst"});
        reset_case = 1;
        done = 1;
        break;
      end

      if (p_aw) begin
        check_val({tag, "_awvalid_hold"}, o_awvalid, 1);
        check_val({tag, "_awaddr_stable"}, o_awaddr, p_awaddr);
      end
      if (p_w) begin
        check_val({tag, "_wvalid_hold"}, o_wvalid, 1);
        check_val({tag, "_wdata_stable"}, {o_wlast, o_wdata}, {p_wlast, p_wdata});
      end
      if (p_ar) begin
        check_val({tag, "_arvalid_hold"}, o_arvalid, 1);
        check_val({tag, "_araddr_stable"}, o_araddr, p_araddr);
      end

      if (o_awvalid && i_awready) begin
        check_val({tag, "_aw_fields"}, {o_awid, o_awaddr, o_awlen, o_awsize, o_awburst},
                  {4'h0, waddr, 8'd15, 3'b010, 2'b01});
        aw_n++;
      end
      if (o_wvalid && i_wready) begin
        check_val({tag, "_w_after_aw"}, aw_n, 1);
        if (wbeat < 16)
          check_val({tag, "_w_beat"}, {o_wstrb, o_wlast, o_wdata},
                    {4'hF, wbeat == 15, vic_line[32*wbeat +: 32]});
        else
          check_val({tag, "_w_extra_beat"}, wbeat, 15);
        wbeat++;
        if (wbeat == 16) w_done = cyc;
      end
      if (i_bvalid && o_bready) b_n++;
      if (o_arvalid) begin
        if (first_ar < 0) first_ar = cyc;
        if (wb) check_val({tag, "_ar_after_b"}, b_n, 1);
        if (i_arready) begin
          check_val({tag, "_ar_fields"}, {o_arid, o_araddr, o_arlen, o_arsize, o_arburst},
                    {4'h0, raddr, 8'd15, 3'b010, 2'b01});
          ar_n++;
          ar_idx = cyc;
        end
      end
      r_hs = i_rvalid && o_rready;
      if (r_hs) rbeat++;
      if (o_refresh) begin
        ref_n++;
        ref_idx = cyc;
        saw_ref = 1;
        check_val({tag, "_refill_line"}, o_refill_line, rd_line);
      end

      p_aw = o_awvalid && !i_awready; p_awaddr = o_awaddr;
      p_w  = o_wvalid && !i_wready;   p_wdata = o_wdata; p_wlast = o_wlast;
      p_ar = o_arvalid && !i_arready; p_araddr = o_araddr;

      if (cyc > 0 && !o_busy) done = 1;
    end

    if (!done) check_val({tag, "_timeout"}, 0, 1);
    if (!reset_case) begin
      check_val({tag, "_refresh_count"}, ref_n, (drop_at >= 0) ? 0 : 1);
      check_val({tag, "_r_beats"}, rbeat, 16);
      check_val({tag, "_w_beats"}, wbeat, wb ? 16 : 0);
      check_val({tag, "_aw_count"}, aw_n, wb ? 1 : 0);
      check_val({tag, "_ar_count"}, ar_n, 1);
      if (exp_ar >= 0)  check_val({tag, "_first_ar_cycle"}, first_ar, exp_ar);
      if (exp_ref >= 0) check_val({tag, "_refresh_cycle"}, ref_idx, exp_ref);
    end
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    i_axi_raddr = '0; i_axi_waddr = '0; i_victim_line = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check_val("reset_refill_line", o_refill_line, '0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      rd_line[32*i +: 32]  = 32'h100 + 32'(i);
      vic_line[32*i +: 32] = 32'hA0 + 32'(i);
    end
    run_miss("clean", 32'h1FC0_0040, 32'h0, 0, 0, -1, -1, -1, 1, 18);
    for (int i = 0; i < 16; i++) rd_line[32*i +: 32] = 32'h200 + 32'(i);
    run_miss("dirty", 32'h0000_2000, 32'h0000_1380, 1, 0, -1, -1, -1, 20, 37);

    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_miss("stall", {$urandom_range(0, 32'h03FF_FFFF), 6'b0}, {$urandom_range(0, 32'h03FF_FFFF), 6'b0},
               1'($urandom % 2), 1, -1, -1, -1, -1, -1);
    end

    fill_random();
    run_miss("drop", 32'h0000_4440, 32'h0, 0, 1, 8, -1, -1, -1, -1);

    fill_random();
    run_miss("rst_wb", 32'h0000_8000, 32'h0000_9000, 1, 0, -1, 7, -1, -1, -1);
    run_miss("after_rst", 32'h0000_8000, 32'h0000_9000, 1, 1, -1, -1, -1, -1, -1);

    fill_random();
    run_miss("early_rlast", 32'h0000_A0C0, 32'h0, 0, 0, -1, -1, 3, 1, 18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
